// File: rtl/loss.sv
// Loss stage: pairs an activation with its target, emits the signed error,
// then optionally relays the activation unit's feedback upstream as a delta.
module loss #(
  parameter int unsigned RESW = 8,
  parameter int unsigned ERRW = 16,
  parameter int unsigned FBKW = ERRW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [RESW-1:0] res_data,
  input  logic            res_valid,
  output logic            res_ready,
  input  logic [RESW-1:0] tgt_data,
  input  logic            tgt_valid,
  output logic            tgt_ready,
  output logic [ERRW-1:0] err_data,
  output logic            err_valid,
  input  logic            err_ready,
  input  logic [FBKW-1:0] fbk_data,
  input  logic            fbk_valid,
  output logic            fbk_ready,
  output logic [FBKW-1:0] dlt_data,
  output logic            dlt_valid,
  input  logic            dlt_ready,
  output logic [15:0]     cnt
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ERR  = 2'd1;
  localparam logic [1:0] S_FBK  = 2'd2;
  localparam logic [1:0] S_DLT  = 2'd3;

  logic [1:0]      state_q, state_d;
  logic            live_q, live_d;
  logic            res_held_q, res_held_d;
  logic            tgt_held_q, tgt_held_d;
  logic [RESW-1:0] res_word_q, res_word_d;
  logic [RESW-1:0] tgt_word_q, tgt_word_d;
  logic            en_lat_q, en_lat_d;
  logic [ERRW-1:0] err_q, err_d;
  logic [FBKW-1:0] dlt_q, dlt_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [RESW:0]   diff;

  // live_q keeps the input readys low until the first edge after reset release.
  assign res_ready = live_q && (state_q == S_IDLE) && !res_held_q;
  assign tgt_ready = live_q && (state_q == S_IDLE) && !tgt_held_q;
  assign err_valid = (state_q == S_ERR);
  assign fbk_ready = (state_q == S_FBK);
  assign dlt_valid = (state_q == S_DLT);
  assign err_data  = err_q;
  assign dlt_data  = dlt_q;
  assign cnt       = cnt_q;

  // One extra bit holds the full -255..+255 range before sign extension.
  assign diff = {1'b0, tgt_word_q} - {1'b0, res_word_q};

  always_comb begin
    state_d    = state_q;
    live_d     = 1'b1;
    res_held_d = res_held_q;
    tgt_held_d = tgt_held_q;
    res_word_d = res_word_q;
    tgt_word_d = tgt_word_q;
    en_lat_d   = en_lat_q;
    err_d      = err_q;
    dlt_d      = dlt_q;
    cnt_d      = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (res_valid && res_ready) begin
          res_held_d = 1'b1;
          res_word_d = res_data;
        end
        if (tgt_valid && tgt_ready) begin
          tgt_held_d = 1'b1;
          tgt_word_d = tgt_data;
        end
        if (res_held_q && tgt_held_q) begin
          state_d    = S_ERR;
          en_lat_d   = en;
          err_d      = {{(ERRW-RESW-1){diff[RESW]}}, diff};
          res_held_d = 1'b0;
          tgt_held_d = 1'b0;
        end
      end
      S_ERR: begin
        if (err_ready) begin
          if (en_lat_q) begin
            state_d = S_FBK;
          end else begin
            state_d = S_IDLE;
            cnt_d   = cnt_q + 16'd1;
          end
        end
      end
      S_FBK: begin
        if (fbk_valid) begin
          dlt_d   = fbk_data;
          state_d = S_DLT;
        end
      end
      default: begin
        if (dlt_ready) begin
          state_d = S_IDLE;
          cnt_d   = cnt_q + 16'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      live_q     <= 1'b0;
      res_held_q <= 1'b0;
      tgt_held_q <= 1'b0;
      res_word_q <= '0;
      tgt_word_q <= '0;
      en_lat_q   <= 1'b0;
      err_q      <= '0;
      dlt_q      <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      live_q     <= live_d;
      res_held_q <= res_held_d;
      tgt_held_q <= tgt_held_d;
      res_word_q <= res_word_d;
      tgt_word_q <= tgt_word_d;
      en_lat_q   <= en_lat_d;
      err_q      <= err_d;
      dlt_q      <= dlt_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_loss.sv
// Directed bench for loss: stimulus pushes hand-computed err/dlt values,
// a negedge monitor pops and compares them on each output transfer.
module tb_loss;
  localparam int RESW = 8;
  localparam int ERRW = 16;
  localparam int FBKW = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b0;
  logic [RESW-1:0] res_data = '0;
  logic res_valid = 1'b0;
  logic res_ready;
  logic [RESW-1:0] tgt_data = '0;
  logic tgt_valid = 1'b0;
  logic tgt_ready;
  logic [ERRW-1:0] err_data;
  logic err_valid;
  logic err_ready = 1'b0;
  logic [FBKW-1:0] fbk_data = '0;
  logic fbk_valid = 1'b0;
  logic fbk_ready;
  logic [FBKW-1:0] dlt_data;
  logic dlt_valid;
  logic dlt_ready = 1'b0;
  logic [15:0] cnt;

  always #5 clk = ~clk;

  loss #(.RESW(RESW), .ERRW(ERRW), .FBKW(FBKW)) dut (
    .clk(clk), .rst(rst), .en(en),
    .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
    .tgt_data(tgt_data), .tgt_valid(tgt_valid), .tgt_ready(tgt_ready),
    .err_data(err_data), .err_valid(err_valid), .err_ready(err_ready),
    .fbk_data(fbk_data), .fbk_valid(fbk_valid), .fbk_ready(fbk_ready),
    .dlt_data(dlt_data), .dlt_valid(dlt_valid), .dlt_ready(dlt_ready),
    .cnt(cnt)
  );

  int checks = 0;
  int errors = 0;
  logic [ERRW-1:0] err_exp[$];
  logic [FBKW-1:0] dlt_exp[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout expected handshake", name);
  endtask

  // Monitor: compares on every output transfer and checks hold/stability.
  logic pv_err = 1'b0, pv_dlt = 1'b0;
  logic [ERRW-1:0] pd_err = '0;
  logic [FBKW-1:0] pd_dlt = '0;
  always @(negedge clk) begin
    if (!rst) begin
      pv_err <= 1'b0;
      pv_dlt <= 1'b0;
    end else begin
      if (pv_err) begin
        check("err_valid_held", err_valid, 1);
        check("err_data_stable", err_data, pd_err);
      end
      if (pv_dlt) begin
        check("dlt_valid_held", dlt_valid, 1);
        check("dlt_data_stable", dlt_data, pd_dlt);
      end
      if (err_valid && err_ready) begin
        if (err_exp.size() == 0) timeout("err_unexpected_transfer");
        else check("err_data", err_data, err_exp.pop_front());
      end
      if (dlt_valid && dlt_ready) begin
        if (dlt_exp.size() == 0) timeout("dlt_unexpected_transfer");
        else check("dlt_data", dlt_data, dlt_exp.pop_front());
      end
      pv_err <= err_valid && !err_ready;
      pd_err <= err_data;
      pv_dlt <= dlt_valid && !dlt_ready;
      pd_dlt <= dlt_data;
    end
  end

  task automatic give_inputs(input logic [7:0] r, input logic [7:0] t,
                             input int tgt_lead, input logic [15:0] exp_err);
    int  cyc = 0;
    bit  rdone = 0, tdone = 0, rh, th;
    err_exp.push_back(exp_err);
    tgt_valid = 1'b1;
    tgt_data  = t;
    while (!(rdone && tdone) && cyc < 100) begin
      if (cyc >= tgt_lead && !rdone) begin
        res_valid = 1'b1;
        res_data  = r;
      end
      @(negedge clk);
      rh = res_valid && res_ready;
      th = tgt_valid && tgt_ready;
      if (tdone && !rdone) begin
        check("tgt_ready_after_capture", tgt_ready, 0);
        check("res_ready_waiting", res_ready, 1);
        check("err_valid_before_res", err_valid, 0);
      end
      @(posedge clk);
      #1;
      if (rh) begin rdone = 1; res_valid = 1'b0; res_data = 8'h5A; end
      if (th) begin tdone = 1; tgt_valid = 1'b0; tgt_data = 8'hA5; end
      cyc++;
    end
    if (!(rdone && tdone)) begin
      timeout("input_handshake");
      return;
    end
    check("err_valid_not_early", err_valid, 0);
    @(posedge clk);
    #1;
    check("err_valid_latency", err_valid, 1);
  endtask

  task automatic finish_err(input int hold, input logic [15:0] exp_cnt);
    bit hs = 0;
    err_ready = 1'b0;
    repeat (hold) begin
      @(negedge clk);
      check("fbk_ready_in_err", fbk_ready, 0);
      @(posedge clk);
      #1;
    end
    err_ready = 1'b1;
    for (int i = 0; i < 20 && !hs; i++) begin
      @(negedge clk);
      hs = err_valid && err_ready;
      @(posedge clk);
      #1;
    end
    err_ready = 1'b0;
    if (!hs) timeout("err_handshake");
    check("cnt_after_err", cnt, exp_cnt);
  endtask

  task automatic do_fbk(input logic [15:0] f, input logic [15:0] exp_dlt);
    bit hs = 0;
    dlt_exp.push_back(exp_dlt);
    fbk_valid = 1'b1;
    fbk_data  = f;
    for (int i = 0; i < 20 && !hs; i++) begin
      @(negedge clk);
      hs = fbk_valid && fbk_ready;
      @(posedge clk);
      #1;
    end
    fbk_valid = 1'b0;
    if (!hs) timeout("fbk_handshake");
  endtask

  task automatic finish_dlt(input int hold, input logic [15:0] exp_cnt_hold,
                            input logic [15:0] exp_cnt);
    bit hs = 0;
    dlt_ready = 1'b0;
    repeat (hold) begin
      @(negedge clk);
      check("cnt_before_dlt", cnt, exp_cnt_hold);
      @(posedge clk);
      #1;
    end
    dlt_ready = 1'b1;
    for (int i = 0; i < 20 && !hs; i++) begin
      @(negedge clk);
      hs = dlt_valid && dlt_ready;
      @(posedge clk);
      #1;
    end
    dlt_ready = 1'b0;
    if (!hs) timeout("dlt_handshake");
    check("cnt_after_dlt", cnt, exp_cnt);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_res_ready", res_ready, 0);
    check("rst_tgt_ready", tgt_ready, 0);
    check("rst_err_valid", err_valid, 0);
    check("rst_dlt_valid", dlt_valid, 0);
    check("rst_cnt", cnt, 0);
    check("rst_err_data", err_data, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("release_res_ready_low", res_ready, 0);
    @(posedge clk);
    #1;
    check("release_res_ready", res_ready, 1);
    check("release_tgt_ready", tgt_ready, 1);

    // en=0 with a pending feedback word that must never be accepted
    en = 1'b0;
    fbk_valid = 1'b1;
    fbk_data  = 16'h1234;
    give_inputs(8'h80, 8'hFF, 0, 16'h007F);
    finish_err(1, 16'd1);
    @(negedge clk);
    check("idle_res_ready", res_ready, 1);
    check("idle_fbk_ready", fbk_ready, 0);
    fbk_valid = 1'b0;
    @(posedge clk);
    #1;

    give_inputs(8'hFF, 8'h00, 0, 16'hFF01);
    finish_err(0, 16'd2);
    give_inputs(8'h00, 8'hFF, 0, 16'h00FF);
    finish_err(0, 16'd3);

    // en=1, en dropped mid-sample must not matter, backpressure on both outputs
    en = 1'b1;
    give_inputs(8'h80, 8'h80, 0, 16'h0000);
    en = 1'b0;
    fbk_valid = 1'b1;
    fbk_data  = 16'h0040;
    finish_err(3, 16'd3);
    do_fbk(16'h0040, 16'h0040);
    finish_dlt(2, 16'd3, 16'd4);

    // target leads activation by 5 cycles
    en = 1'b0;
    give_inputs(8'h10, 8'h30, 5, 16'h0020);
    finish_err(0, 16'd5);

    // reset while waiting in FBK
    en = 1'b1;
    give_inputs(8'h30, 8'h10, 0, 16'hFFE0);
    finish_err(0, 16'd5);
    check("in_fbk_ready", fbk_ready, 1);
    rst = 1'b0;
    #1;
    check("abort_fbk_ready", fbk_ready, 0);
    check("abort_res_ready", res_ready, 0);
    check("abort_tgt_ready", tgt_ready, 0);
    check("abort_err_valid", err_valid, 0);
    check("abort_dlt_valid", dlt_valid, 0);
    check("abort_cnt", cnt, 0);
    check("abort_err_data", err_data, 0);
    check("abort_dlt_data", dlt_data, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rerelease_ready_low", tgt_ready, 0);
    @(posedge clk);
    #1;
    check("rerelease_res_ready", res_ready, 1);
    check("rerelease_tgt_ready", tgt_ready, 1);

    give_inputs(8'h01, 8'hFE, 0, 16'h00FD);
    finish_err(0, 16'd0);
    do_fbk(16'hFF80, 16'hFF80);
    finish_dlt(0, 16'd0, 16'd1);

    repeat (3) @(posedge clk);
    #1;
    check("err_queue_drained", err_exp.size(), 0);
    check("dlt_queue_drained", dlt_exp.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck expected completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/loss.md
LOSS -- requirements
Module: loss

Interface
REQ-001 Parameter: RESW, default 8, activation and target width (unsigned Q0.8).
REQ-002 Parameter: ERRW, default 16, error width (signed Q8.8).
REQ-003 Parameter: FBKW, default ERRW, feedback and delta width (signed Q8.8).
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 Port: clk  in  1  clock; all state updates on its rising edge.
REQ-006 Port: rst  in  1  asynchronous, active-low reset.
REQ-007 Port: en  in  1  training enable; high means run the backward phase.
REQ-008 Ports: res_data in RESW, res_valid in 1, res_ready out 1  activation input stream.
REQ-009 Ports: tgt_data in RESW, tgt_valid in 1, tgt_ready out 1  target input stream.
REQ-010 Ports: err_data out ERRW, err_valid out 1, err_ready in 1  error output stream, which drives the activation unit's err input.
REQ-011 Ports: fbk_data in FBKW, fbk_valid in 1, fbk_ready out 1  feedback input stream from the activation unit.
REQ-012 Ports: dlt_data out FBKW, dlt_valid out 1, dlt_ready in 1  delta output stream to the upstream layer.
REQ-013 Port: cnt  out 16  count of completed samples.

Function
REQ-014 A transfer SHALL occur on a rising edge where valid and ready are both high; valid/data SHALL hold stable until that transfer.
REQ-015 FSM states SHALL be IDLE, ERR, FBK, DLT.
REQ-016 IDLE: res_ready and tgt_ready SHALL be independently high until their own word is captured, then low; the captured word SHALL be held.
REQ-017 Arrival order of res and tgt SHALL not matter, including arrival on the same edge.
REQ-018 IDLE -> ERR SHALL occur on the edge after both words are held; en SHALL be sampled on that edge and latched for the whole sample.
REQ-019 Error SHALL be computed as err_data = sign-extend(zero-extend(tgt) - zero-extend(res)) to ERRW, giving the range -255..+255; it SHALL be registered at entry to ERR.
REQ-020 ERR: err_valid=1. On the err transfer, the FSM SHALL go to FBK if latched en=1, else to IDLE.
REQ-021 FBK: fbk_ready=1. On the fbk transfer, fbk_data SHALL be captured into dlt_data and the FSM SHALL go to DLT.
REQ-022 DLT: dlt_valid=1. On the dlt transfer, the FSM SHALL go to IDLE.
REQ-023 cnt SHALL increment by 1 on the final handshake of each sample (err if en=0, dlt if en=1) and SHALL wrap from 0xFFFF to 0x0000.
REQ-024 Valid from a later phase SHALL never be raised early; fbk_valid arriving outside FBK SHALL be left pending (fbk_ready=0).
REQ-025 Back-to-back operation: in the cycle after returning to IDLE, res_ready and tgt_ready SHALL be high, giving at most 1 bubble per sample.
REQ-026 Minimum latency SHALL be: second input accepted at edge N -> err_valid high after edge N+1.

Reset
REQ-027 While rst=0 the block SHALL hold: state=IDLE, all *_valid=0, all *_ready=0, err_data=0, dlt_data=0, cnt=0, and held res/tgt words cleared.
REQ-028 res_ready and tgt_ready SHALL rise on the first rising edge after rst deasserts.
REQ-029 Reset asserted in any state SHALL abort the sample immediately, with no partial handshake or cnt increment.

Verification
REQ-030 en=0, res=0x80, tgt=0xFF -> err=0x007F; fbk_ready stays 0; return to IDLE; cnt=1.
REQ-031 en=0, res=0xFF, tgt=0x00 -> err=0xFF01; then res=0x00, tgt=0xFF -> err=0x00FF.
REQ-032 en=1, res=0x80, tgt=0x80 -> err=0x0000; fbk=0x0040 -> dlt=0x0040; cnt increments only after the dlt transfer.
REQ-033 tgt presented 5 cycles before res -> tgt_ready drops after tgt capture, res_ready stays high; err_valid only after res capture; result is order-independent.
REQ-034 Hold err_ready low 3 cycles, then dlt_ready low 2 cycles -> valids held high, data stable, no duplicate transfers.
REQ-035 Assert rst while in FBK -> all valids and readys 0, cnt=0; after release, res_ready and tgt_ready are high 1 edge later and a fresh sample completes correctly.
